// File: rtl/led_594_refresh_ctrl.sv
// Refresh sequencer for a 74HC594 LED chain: snapshots leds, shifts them out MSB first, pulses RCLK.
// Optional LED_594_CLEAR_EN adds clr_n and a CLEAR state that wipes the chain after reset.
module led_594_refresh_ctrl #(
    parameter int NUM_LEDS    = 16,
    parameter int CLK_DIV     = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_LEDS-1:0] leds,
    input  logic                update_req,
    output logic                slowtick,
    output logic                ser,
    output logic                srclk,
    output logic                rclk,
    output logic                busy,
    output logic                done
`ifdef LED_594_CLEAR_EN
    ,
    output logic                clr_n
`endif
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NUM_LEDS + 1);
    localparam int TW = $clog2(REFRESH_DIV + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLK_HI,
        ST_LATCH
`ifdef LED_594_CLEAR_EN
        ,
        ST_CLEAR
`endif
    } state_t;

`ifdef LED_594_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t              state_q, state_d;
    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_LEDS-1:0] shreg_q, shreg_d;
    logic                pending_q, pending_d;
    logic                ser_q, ser_d;
    logic                done_q, done_d;

    logic                tick;
    logic                div_end;
    logic [NUM_LEDS-1:0] shreg_shifted;

    assign tick          = (timer_q == TW'(REFRESH_DIV - 1));
    assign div_end       = (div_cnt_q == DW'(CLK_DIV - 1));
    assign shreg_shifted = shreg_q << 1;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_end ? '0 : div_cnt_q + DW'(1);
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ser_d     = ser_q;
        done_d    = 1'b0;
        pending_d = pending_q | tick | update_req;
        timer_d   = tick ? '0 : timer_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                if (pending_q) begin
                    shreg_d   = leds;
                    bit_cnt_d = BW'(NUM_LEDS - 1);
                    ser_d     = leds[NUM_LEDS-1];
                    // A request arriving in the capture cycle still earns another frame.
                    pending_d = tick | update_req;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_end) begin
                    state_d = ST_CLK_HI;
                end
            end
            ST_CLK_HI: begin
                if (div_end) begin
                    if (bit_cnt_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        shreg_d   = shreg_shifted;
                        ser_d     = shreg_shifted[NUM_LEDS-1];
                        bit_cnt_d = bit_cnt_q - BW'(1);
                        state_d   = ST_SETUP;
                    end
                end
            end
            ST_LATCH: begin
                if (div_end) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`ifdef LED_594_CLEAR_EN
            ST_CLEAR: begin
                if (div_end) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= RESET_STATE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            shreg_q   <= '0;
            pending_q <= 1'b0;
            ser_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            shreg_q   <= shreg_d;
            pending_q <= pending_d;
            ser_q     <= ser_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        srclk = (state_q == ST_CLK_HI);
        rclk  = (state_q == ST_LATCH);
`ifdef LED_594_CLEAR_EN
        // CLEAR is the reset state, so busy and clr_n are gated by resetn while it is held.
        busy  = (state_q != ST_IDLE) && resetn;
        clr_n = resetn && (state_q != ST_CLEAR);
`else
        busy  = (state_q != ST_IDLE);
`endif
    end

    assign slowtick = tick;
    assign ser      = ser_q;
    assign done     = done_q;

endmodule
